// File: rtl/prog_done_ctrl.sv
// prog_done_ctrl: completion side of the Start/Done run handshake.
// Runs a program after Start falls, detects the halt instruction, drains
// the pipeline for DRAIN_CYCLES and raises Done.  It also reports the Running
// level for PC counting, a saturating per-run cycle count and the index of the
// program being run.
// Optional feature: define PROG_DONE_WATCHDOG_EN to enable a run-length
// watchdog that forces completion and raises Timeout at MAX_CYCLES.
module prog_done_ctrl #(
  parameter int unsigned CYCLE_W      = 16,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned NUM_PROGS    = 3,
  parameter int unsigned PROG_W       = 2,
  parameter int unsigned MAX_CYCLES   = 32'h0000_FFFF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               HaltReq,
  output logic               Running,
  output logic               Done,
  output logic [CYCLE_W-1:0] CycleCount,
  output logic [PROG_W-1:0]  ProgIndex,
  output logic               Timeout
);

  // Drain counter only needs to hold DRAIN_CYCLES-1.
  localparam int unsigned DW           = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned DRAIN_LOAD_I = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DRAIN_LOAD_I[DW-1:0];
  localparam logic [PROG_W-1:0] PROG_LAST = PROG_W'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CYCLE_W-1:0]  cycle_q, cycle_d;
  logic [PROG_W-1:0]   prog_q, prog_d;
  logic [DW-1:0]       drain_q, drain_d;

  // Cycle counter never wraps: it sticks at all-ones.
  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] c);
    if (c == {CYCLE_W{1'b1}}) begin
      return c;
    end
    return c + CYCLE_W'(1);
  endfunction

  // Program index wraps back to 0 after the last program.
  function automatic logic [PROG_W-1:0] wrap_inc(input logic [PROG_W-1:0] p);
    if (p == PROG_LAST) begin
      return '0;
    end
    return p + PROG_W'(1);
  endfunction

`ifdef PROG_DONE_WATCHDOG_EN
  localparam int unsigned WD_HIT = MAX_CYCLES - 1;

  logic timeout_q, timeout_d;
  logic wd_hit;

  // Watchdog trips on the last allowed RUN cycle.
  assign wd_hit = (32'(cycle_q) == WD_HIT);
`else
  logic unused_max_cycles;
  assign unused_max_cycles = (MAX_CYCLES == 0);
`endif

  // Next-state and counter updates for the run handshake FSM.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    prog_d  = prog_q;
    drain_d = drain_q;
`ifdef PROG_DONE_WATCHDOG_EN
    timeout_d = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (!Start) begin
          state_d = S_RUN;
          cycle_d = '0;
`ifdef PROG_DONE_WATCHDOG_EN
          timeout_d = 1'b0;
`endif
        end
      end

      S_RUN: begin
        // Every RUN cycle is counted, including the halt cycle.
        cycle_d = sat_inc(cycle_q);
        if (Start) begin
          // Restart abort wins over a coincident halt.
          state_d = S_ARMED;
        end else if (HaltReq) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
`ifdef PROG_DONE_WATCHDOG_EN
        else if (wd_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
`endif
      end

      S_DRAIN: begin
        if (Start) begin
          state_d = S_ARMED;
        end else if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end

      S_DONE: begin
        if (Start) begin
          state_d = S_ARMED;
          prog_d  = wrap_inc(prog_q);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers; reset aborts any run without Done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cycle_q <= '0;
      prog_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      prog_q  <= prog_d;
      drain_q <= drain_d;
    end
  end

`ifdef PROG_DONE_WATCHDOG_EN
  // Timeout flag, cleared only when a new run begins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

  assign Running    = (state_q == S_RUN);
  assign Done       = (state_q == S_DONE);
  assign CycleCount = cycle_q;
  assign ProgIndex  = prog_q;

endmodule

// File: tb/tb_prog_done_ctrl.sv
// Bench for prog_done_ctrl: completions of the main instance are predicted
// into a queue when the halt is driven and checked when Done rises.
module tb_prog_done_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset_n;

  // main instance: DRAIN_CYCLES=2, MAX_CYCLES=20
  logic        start_m, halt_m, run_m, done_m, to_m;
  logic [15:0] cc_m;
  logic [1:0]  pi_m;
  // zero-drain instance
  logic        start_z, halt_z, run_z, done_z, to_z;
  logic [15:0] cc_z;
  logic [1:0]  pi_z;
  // narrow counter instance for saturation, DRAIN_CYCLES=1
  logic        start_s, halt_s, run_s, done_s, to_s;
  logic [3:0]  cc_s;
  logic [1:0]  pi_s;

  prog_done_ctrl #(.CYCLE_W(16), .DRAIN_CYCLES(2), .NUM_PROGS(3), .PROG_W(2), .MAX_CYCLES(20)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start_m), .HaltReq(halt_m),
    .Running(run_m), .Done(done_m), .CycleCount(cc_m), .ProgIndex(pi_m), .Timeout(to_m));

  prog_done_ctrl #(.CYCLE_W(16), .DRAIN_CYCLES(0), .NUM_PROGS(3), .PROG_W(2)) dut_z (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start_z), .HaltReq(halt_z),
    .Running(run_z), .Done(done_z), .CycleCount(cc_z), .ProgIndex(pi_z), .Timeout(to_z));

  prog_done_ctrl #(.CYCLE_W(4), .DRAIN_CYCLES(1), .NUM_PROGS(3), .PROG_W(2)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start_s), .HaltReq(halt_s),
    .Running(run_s), .Done(done_s), .CycleCount(cc_s), .ProgIndex(pi_s), .Timeout(to_s));

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int cc;
    int pi;
    int to;
    int at;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Scoreboard: every rising Done of the main instance must match a prediction.
  always @(negedge Clk) begin
    if (done_m && !done_prev) begin
      chk("sb_pending", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("sb_cc", cc_m, mon_e.cc);
        chk("sb_pi", pi_m, mon_e.pi);
        chk("sb_to", to_m, mon_e.to);
        chk("sb_lat", cyc, mon_e.at);
      end
    end
    done_prev <= done_m;
  end

  task automatic wait_done();
    for (int k = 0; k < 10 && !done_m; k++) tick();
    chk("done_wait", done_m, 1);
  endtask

  // One full run on the main instance: Start 3 cycles, halt on RUN cycle n_run.
  task automatic run_prog(input int n_run, input int exp_pi);
    int rcnt;
    start_m = 1'b1;
    tick();
    chk("rp_done_fall", done_m, 0);
    chk("rp_pi", pi_m, exp_pi);
    tick(2);
    start_m = 1'b0;
    tick();
    chk("rp_run_entry", run_m, 1);
    chk("rp_cc0", cc_m, 0);
    rcnt = 0;
    for (int i = 1; i <= n_run; i++) begin
      if (run_m) rcnt++;
      if (i == n_run) begin
        halt_m = 1'b1;
        sb_q.push_back('{cc: n_run, pi: exp_pi, to: 0, at: cyc + 3});
      end
      tick();
      halt_m = 1'b0;
    end
    chk("rp_run_cycles", rcnt, n_run);
    chk("rp_run_off", run_m, 0);
    chk("rp_cc", cc_m, n_run);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0;
    start_m = 1'b0; halt_m = 1'b0;
    start_z = 1'b0; halt_z = 1'b0;
    start_s = 1'b0; halt_s = 1'b0;
    tick(2);
    Reset_n = 1'b1;
    tick();
    chk("rst_run", run_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_cc", cc_m, 0);
    chk("rst_pi", pi_m, 0);
    chk("rst_to", to_m, 0);

    // Reset mid-run clears outputs before the next edge.
    start_z = 1'b1; tick();
    start_z = 1'b0; tick();
    chk("t1_run", run_z, 1);
    tick(37);
    chk("t1_cc37", cc_z, 37);
    Reset_n = 1'b0;
    #1;
    chk("t1_async_run", run_z, 0);
    chk("t1_async_cc", cc_z, 0);
    chk("t1_async_done", done_z, 0);
    #2;
    Reset_n = 1'b1;
    tick();
    chk("t1_idle_run", run_z, 0);
    chk("t1_idle_done", done_z, 0);

    // HaltReq in IDLE does nothing.
    halt_z = 1'b1; tick(); halt_z = 1'b0;
    chk("t5_idle_halt_run", run_z, 0);
    chk("t5_idle_halt_done", done_z, 0);

    // Zero drain: Done on the edge that samples HaltReq.
    start_z = 1'b1; tick();
    start_z = 1'b0; tick();
    chk("t5_cc0", cc_z, 0);
    halt_z = 1'b1; tick(); halt_z = 1'b0;
    chk("t5_done", done_z, 1);
    chk("t5_cc1", cc_z, 1);
    chk("t5_run_off", run_z, 0);
    halt_z = 1'b1; tick(); halt_z = 1'b0;
    tick();
    chk("t5_done_hold", done_z, 1);
    chk("t5_cc_hold", cc_z, 1);
    chk("t5_pi_hold", pi_z, 0);
    start_z = 1'b1; tick(); start_z = 1'b0;
    chk("t5_done_fall", done_z, 0);
    chk("t5_pi_adv", pi_z, 1);

    // Normal runs and program index wrap.
    run_prog(10, 0);
    run_prog(4, 1);
    run_prog(6, 2);

    // Start and HaltReq together: abort wins, no Done.
    start_m = 1'b1; tick();
    chk("t4_done_fall", done_m, 0);
    chk("t4_pi_wrap", pi_m, 0);
    tick();
    start_m = 1'b0; tick();
    chk("t4_run", run_m, 1);
    tick(4);
    start_m = 1'b1; halt_m = 1'b1; tick();
    halt_m = 1'b0;
    chk("t4_abort_run", run_m, 0);
    chk("t4_abort_done", done_m, 0);
    chk("t4_abort_pi", pi_m, 0);
    start_m = 1'b0; tick();
    chk("t4_rerun", run_m, 1);
    chk("t4_rerun_cc0", cc_m, 0);
    tick(3);

    // Start during DRAIN aborts without Done.
    halt_m = 1'b1; tick(); halt_m = 1'b0;
    chk("t4_drain_run", run_m, 0);
    start_m = 1'b1; tick();
    start_m = 1'b0; tick();
    chk("t4_drain_abort_run", run_m, 1);
    chk("t4_drain_abort_cc0", cc_m, 0);
    chk("t4_drain_abort_done", done_m, 0);
    tick();
    halt_m = 1'b1;
    sb_q.push_back('{cc: 2, pi: 0, to: 0, at: cyc + 3});
    tick(); halt_m = 1'b0;
    wait_done();

    // Cycle counter saturation on the narrow instance.
    start_s = 1'b1; tick();
    start_s = 1'b0; tick();
    tick(20);
    chk("sat_cc", cc_s, 15);
    chk("sat_run", run_s, 1);
    halt_s = 1'b1; tick(); halt_s = 1'b0;
    chk("sat_cc_halt", cc_s, 15);
    chk("sat_drain_done", done_s, 0);
    tick();
    chk("sat_done", done_s, 1);

`ifdef PROG_DONE_WATCHDOG_EN
    // Watchdog forces completion after MAX_CYCLES RUN cycles.
    start_m = 1'b1; tick();
    chk("wd_pi", pi_m, 1);
    start_m = 1'b0; tick();
    chk("wd_to0", to_m, 0);
    tick(19);
    sb_q.push_back('{cc: 20, pi: 1, to: 1, at: cyc + 1});
    tick();
    chk("wd_cc", cc_m, 20);
    chk("wd_to", to_m, 1);
    chk("wd_done", done_m, 1);
    start_m = 1'b1; tick();
    chk("wd_to_armed", to_m, 1);
    start_m = 1'b0; tick();
    chk("wd_to_clear", to_m, 0);
    chk("wd_run", run_m, 1);
`endif

    tick(3);
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
